// File: rtl/fpio_pkg.sv
// fpio_pkg: definitions shared by the fpio link blocks.
//   DIV_W      width of the beat-rate divisor port (same encoding as fpio_tx)
//   rx_state_e receiver frame state
//   beats()    number of link beats that make up one assembled word
package fpio_pkg;

  localparam int DIV_W = 32;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_SAMPLE,
    RX_WAIT_LOW
  } rx_state_e;

  function automatic int beats(input int data_w, input int word_w);
    return word_w / data_w;
  endfunction

endpackage

// File: rtl/fpio_if.sv
// fpio_if: the fpio link wires between fpio_tx and fpio_rx.
//   dat    beat data, DATA_WIDTH bits
//   valid  high for the whole frame
interface fpio_if #(
  parameter int DATA_WIDTH = 4
);
  logic [DATA_WIDTH-1:0] dat;
  logic                  valid;

  modport send (output dat, output valid);
  modport recv (input  dat, input  valid);
endinterface

// File: rtl/fpio_sync_fifo.sv
// fpio_sync_fifo: single-clock word FIFO with first-word fall-through head.
//   clk, rstn            clock, async active-low reset (empties the FIFO)
//   push_i, push_data_i  write request and word
//   pop_i                remove head; ignored while empty
//   head_o               registered head entry, meaningful when !empty_o
//   full_o, empty_o      occupancy flags
//   level_o              occupancy, 0..DEPTH
//   drop_o               pulses when a push is refused (full with no pop)
module fpio_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           push_data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           head_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic                       drop_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  // Pointers carry one extra bit so level is a plain subtraction.
  logic [AW:0]      wr_q, rd_q;
  logic             pop_ok, push_ok;

  assign level_o = wr_q - rd_q;
  assign full_o  = (level_o == (AW+1)'(DEPTH));
  assign empty_o = (level_o == '0);
  assign pop_ok  = pop_i && !empty_o;
  // A pop frees the slot on the same edge, so a full FIFO still accepts.
  assign push_ok = push_i && (!full_o || pop_ok);
  assign drop_o  = push_i && !push_ok;
  assign head_o  = mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_q[AW-1:0]] <= push_data_i;
        wr_q                <= wr_q + 1'b1;
      end
      if (pop_ok) rd_q <= rd_q + 1'b1;
    end
  end

endmodule

// File: rtl/fpio_rx.sv
// fpio_rx: receive side of the fpio link.
//   clk, rstn   clock, async active-low reset
//   en          receiver enable; low drops any partial word
//   divisor     beat period = divisor+1 clk, latched at frame start
//   dat_i       fpio link (dat, valid)
//   rd_*        FIFO head word / valid / ready handshake
//   level       FIFO occupancy
//   overflow    sticky: completed word dropped on full FIFO
//   frame_err   sticky: valid low at a mid-frame sample point
//   clr_err     clears both sticky flags (a same-cycle set wins)
module fpio_rx
  import fpio_pkg::*;
#(
  parameter int DATA_WIDTH = 4,
  parameter int WORD_WIDTH = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          en,
  input  logic [DIV_W-1:0]              divisor,
  fpio_if.recv                          dat_i,
  output logic [WORD_WIDTH-1:0]         rd_data,
  output logic                          rd_valid,
  input  logic                          rd_ready,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          overflow,
  output logic                          frame_err,
  input  logic                          clr_err
);
  localparam int BEATS = beats(DATA_WIDTH, WORD_WIDTH);
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  // Two-flop synchronizers on the link.
  logic [DATA_WIDTH-1:0] dat_s1_q, dat_s_q;
  logic                  vld_s1_q, vld_s_q;

  rx_state_e             state_q, state_d;
  logic [DIV_W-1:0]      cnt_q, cnt_d, div_q, div_d;
  logic [BW-1:0]         beat_q, beat_d;
  logic [WORD_WIDTH-1:0] word_q, word_d, word_nxt;
  logic                  overflow_q, overflow_d, frame_err_q, frame_err_d;
  logic                  push, ferr_set;
  logic                  fifo_full, fifo_empty, fifo_drop;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dat_s1_q <= '0;
      dat_s_q  <= '0;
      vld_s1_q <= 1'b0;
      vld_s_q  <= 1'b0;
    end else begin
      dat_s1_q <= dat_i.dat;
      dat_s_q  <= dat_s1_q;
      vld_s1_q <= dat_i.valid;
      vld_s_q  <= vld_s1_q;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= RX_IDLE;
      cnt_q       <= '0;
      div_q       <= '0;
      beat_q      <= '0;
      word_q      <= '0;
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      div_q       <= div_d;
      beat_q      <= beat_d;
      word_q      <= word_d;
      overflow_q  <= overflow_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    div_d    = div_q;
    beat_d   = beat_q;
    word_d   = word_q;
    push     = 1'b0;
    ferr_set = 1'b0;
    // Word as it looks once the current beat lands in its slot; this is
    // also the push data so the last beat is not a cycle late.
    word_nxt = word_q;
    word_nxt[beat_q*DATA_WIDTH +: DATA_WIDTH] = dat_s_q;

    unique case (state_q)
      RX_IDLE: begin
        if (en && vld_s_q) begin
          div_d   = divisor;
          cnt_d   = divisor >> 1;   // first sample lands mid-beat
          beat_d  = '0;
          word_d  = '0;
          state_d = RX_SAMPLE;
        end
      end
      RX_SAMPLE: begin
        if (!en) begin
          state_d = RX_IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - DIV_W'(1);
        end else if (!vld_s_q) begin
          ferr_set = 1'b1;
          state_d  = RX_IDLE;
        end else begin
          word_d = word_nxt;
          if (beat_q == BW'(BEATS-1)) begin
            push    = 1'b1;
            state_d = RX_WAIT_LOW;
          end else begin
            beat_d = beat_q + 1'b1;
            cnt_d  = div_q;
          end
        end
      end
      RX_WAIT_LOW: begin
        if (!en || !vld_s_q) state_d = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_comb begin
    overflow_d  = clr_err ? 1'b0 : overflow_q;
    frame_err_d = clr_err ? 1'b0 : frame_err_q;
    if (fifo_drop) overflow_d  = 1'b1;
    if (ferr_set)  frame_err_d = 1'b1;
  end

  fpio_sync_fifo #(
    .WIDTH (WORD_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rstn        (rstn),
    .push_i      (push),
    .push_data_i (word_nxt),
    .pop_i       (rd_ready),
    .head_o      (rd_data),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .level_o     (level),
    .drop_o      (fifo_drop)
  );

  assign rd_valid  = !fifo_empty;
  assign overflow  = overflow_q;
  assign frame_err = frame_err_q;

  logic unused_full;
  assign unused_full = fifo_full;

endmodule

// File: tb/tb_fpio_rx.sv
// tb_fpio_rx: directed test of fpio_rx with hand-computed expected words.
module tb_fpio_rx;
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        en = 1'b0;
  logic [31:0] divisor = '0;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        rd_ready = 1'b0;
  logic [3:0]  level;
  logic        overflow, frame_err;
  logic        clr_err = 1'b0;
  int          n_chk = 0, n_err = 0;

  fpio_if #(.DATA_WIDTH(4)) link ();

  fpio_rx #(.DATA_WIDTH(4), .WORD_WIDTH(32), .FIFO_DEPTH(8)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .en        (en),
    .divisor   (divisor),
    .dat_i     (link),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .level     (level),
    .overflow  (overflow),
    .frame_err (frame_err),
    .clr_err   (clr_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Sends nb beats of w (LSB beat first), each divisor+1 clk long. Valid
  // leads beat 0 by one clk: the receiver's first sample comes one clk
  // after it detects valid, which at divisor 0 would otherwise hit beat 1.
  task automatic send_frame(input int div, input logic [31:0] w, input int nb);
    divisor    = 32'(div);
    link.valid = 1'b1;
    link.dat   = 4'h0;
    @(negedge clk);
    for (int b = 0; b < nb; b++) begin
      link.dat = w[b*4 +: 4];
      repeat (div + 1) @(negedge clk);
    end
    link.valid = 1'b0;
    link.dat   = 4'h0;
  endtask

  task automatic pop_chk(input string tag, input logic [31:0] exp);
    check({tag, "_vld"}, 32'(rd_valid), 32'd1);
    check(tag, rd_data, exp);
    rd_ready = 1'b1;
    @(negedge clk);
    rd_ready = 1'b0;
  endtask

  initial begin
    link.valid = 1'b0;
    link.dat   = 4'h0;
    repeat (3) @(negedge clk);
    check("rst_vld",  32'(rd_valid),  32'd0);
    check("rst_data", rd_data,        32'd0);
    check("rst_lvl",  32'(level),     32'd0);
    check("rst_ovf",  32'(overflow),  32'd0);
    check("rst_ferr", 32'(frame_err), 32'd0);
    rstn = 1'b1;
    en   = 1'b1;
    repeat (2) @(negedge clk);

    // Empty pop is ignored.
    rd_ready = 1'b1; @(negedge clk); rd_ready = 1'b0;
    check("empty_pop_lvl", 32'(level), 32'd0);

    // divisor 3, single word.
    send_frame(3, 32'h1234_5678, 8);
    repeat (6) @(negedge clk);
    check("t1_lvl", 32'(level), 32'd1);
    pop_chk("t1_word", 32'h1234_5678);
    check("t1_lvl0", 32'(level), 32'd0);

    // divisor 0, two frames with a 1-clk gap.
    send_frame(0, 32'hDEAD_BEEF, 8);
    @(negedge clk);
    send_frame(0, 32'hCAFE_F00D, 8);
    repeat (6) @(negedge clk);
    check("t2_lvl", 32'(level), 32'd2);
    pop_chk("t2_w0", 32'hDEAD_BEEF);
    pop_chk("t2_w1", 32'hCAFE_F00D);
    check("t2_ovf",  32'(overflow),  32'd0);
    check("t2_ferr", 32'(frame_err), 32'd0);

    // Nine words into an eight-deep FIFO.
    for (int i = 0; i < 9; i++) begin
      send_frame(0, 32'h1000_0000 + 32'(i * 32'h0101_0101), 8);
      @(negedge clk);
    end
    repeat (6) @(negedge clk);
    check("t3_lvl", 32'(level),    32'd8);
    check("t3_ovf", 32'(overflow), 32'd1);
    for (int i = 0; i < 8; i++)
      pop_chk($sformatf("t3_w%0d", i), 32'h1000_0000 + 32'(i * 32'h0101_0101));
    check("t3_vld0", 32'(rd_valid), 32'd0);
    clr_err = 1'b1; @(negedge clk); clr_err = 1'b0;
    check("t3_clr", 32'(overflow), 32'd0);

    // Valid dropped after beat 3 of 8 at divisor 5.
    send_frame(5, 32'h8765_4321, 3);
    repeat (12) @(negedge clk);
    check("t4_ferr", 32'(frame_err), 32'd1);
    check("t4_lvl",  32'(level),     32'd0);
    send_frame(5, 32'h0BAD_F00D, 8);
    repeat (8) @(negedge clk);
    check("t4_lvl1", 32'(level), 32'd1);
    pop_chk("t4_word", 32'h0BAD_F00D);
    clr_err = 1'b1; @(negedge clk); clr_err = 1'b0;
    check("t4_clr", 32'(frame_err), 32'd0);

    // en dropped mid-frame, then a fresh frame.
    send_frame(5, 32'hFFFF_FFFF, 3);
    en = 1'b0;
    repeat (12) @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    send_frame(2, 32'h5A5A_A5A5, 8);
    repeat (6) @(negedge clk);
    check("t5_ferr", 32'(frame_err), 32'd0);
    check("t5_lvl",  32'(level),     32'd1);
    pop_chk("t5_word", 32'h5A5A_A5A5);

    // Reset mid-frame with three words queued and frame_err set.
    for (int i = 0; i < 3; i++) begin
      send_frame(0, 32'h0000_0100 + 32'(i), 8);
      @(negedge clk);
    end
    send_frame(1, 32'h0, 2);
    repeat (8) @(negedge clk);
    check("t6_pre_lvl",  32'(level),     32'd3);
    check("t6_pre_ferr", 32'(frame_err), 32'd1);
    link.valid = 1'b1;
    link.dat   = 4'h5;
    divisor    = 32'd3;
    repeat (6) @(negedge clk);
    rstn = 1'b0;
    #1;
    check("t6_lvl",  32'(level),     32'd0);
    check("t6_vld",  32'(rd_valid),  32'd0);
    check("t6_ovf",  32'(overflow),  32'd0);
    check("t6_ferr", 32'(frame_err), 32'd0);
    link.valid = 1'b0;
    link.dat   = 4'h0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    send_frame(3, 32'h2468_ACE0, 8);
    repeat (6) @(negedge clk);
    check("t6_lvl1", 32'(level), 32'd1);
    pop_chk("t6_word", 32'h2468_ACE0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
